// File: rtl/datapath_pkg.sv
// Shared datapath definitions: ALU and shifter opcodes plus the default datapath width.
// Shifter and ALU stages both import this so their encodings cannot drift apart.
package datapath_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_NOT = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        SH_PASS = 2'b00,
        SH_LEFT = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } shift_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: ADD/SUB/AND/NOT on the A operand and the shifter output.
// The overflow output applies to ADD/SUB only and is forced low for the logic ops.
module alu_core #(
    parameter int WIDTH = datapath_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] sout,
    input  logic [1:0]       alu_op,
    output logic [WIDTH-1:0] result,
    output logic             v
);
    import datapath_pkg::*;

    logic a_msb;
    logic b_msb;
    logic r_msb;

    assign a_msb = ain[WIDTH-1];
    assign b_msb = sout[WIDTH-1];
    assign r_msb = result[WIDTH-1];

    always_comb begin
        result = '0;
        v      = 1'b0;
        unique case (alu_op_t'(alu_op))
            ALU_ADD: begin
                result = ain + sout;
                v      = (a_msb == b_msb) && (r_msb != a_msb);
            end
            ALU_SUB: begin
                result = ain - sout;
                v      = (a_msb != b_msb) && (r_msb != a_msb);
            end
            ALU_AND: result = ain & sout;
            ALU_NOT: result = ~sout;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_stage.sv
// Registered ALU stage: C result register with valid/ready handshake toward writeback,
// plus the Z/N/V status register and a sticky overflow bit used by conditional branches.
module alu_stage #(
    parameter int WIDTH = datapath_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] sout,
    input  logic [1:0]       alu_op,
    input  logic             load_s,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] c_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             z_flag,
    output logic             n_flag,
    output logic             v_flag,
    output logic             v_sticky,
    input  logic             clr_v
);
    import datapath_pkg::*;

    logic [WIDTH-1:0] core_result;
    logic             core_v;
    logic             accept;

    logic [WIDTH-1:0] c_d, c_q;
    logic             out_valid_d, out_valid_q;
    logic             z_d, z_q;
    logic             n_d, n_q;
    logic             v_d, v_q;
    logic             v_sticky_d, v_sticky_q;

    alu_core #(.WIDTH(WIDTH)) u_alu_core (
        .ain    (ain),
        .sout   (sout),
        .alu_op (alu_op),
        .result (core_result),
        .v      (core_v)
    );

    // Ready looks through the output register so a consume and an accept share one edge.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        c_d         = c_q;
        out_valid_d = out_valid_q;
        z_d         = z_q;
        n_d         = n_q;
        v_d         = v_q;
        v_sticky_d  = v_sticky_q & ~clr_v;

        if (accept) begin
            c_d         = core_result;
            out_valid_d = 1'b1;
            if (load_s) begin
                z_d = (core_result == '0);
                n_d = core_result[WIDTH-1];
                v_d = core_v;
                // A setting update beats a same-cycle clear.
                if (core_v) begin
                    v_sticky_d = 1'b1;
                end
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q         <= '0;
            out_valid_q <= 1'b0;
            z_q         <= 1'b1;
            n_q         <= 1'b0;
            v_q         <= 1'b0;
            v_sticky_q  <= 1'b0;
        end else begin
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
            z_q         <= z_d;
            n_q         <= n_d;
            v_q         <= v_d;
            v_sticky_q  <= v_sticky_d;
        end
    end

    assign c_out     = c_q;
    assign out_valid = out_valid_q;
    assign z_flag    = z_q;
    assign n_flag    = n_q;
    assign v_flag    = v_q;
    assign v_sticky  = v_sticky_q;

endmodule

// File: tb/tb_alu_stage.sv
// Directed bench for alu_stage: a reference model pushes expected results into a
// scoreboard queue at accept time, and they are popped and compared one cycle later.
module tb_alu_stage;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] ain = '0;
    logic [W-1:0] sout = '0;
    logic [1:0]   alu_op = 2'b00;
    logic         load_s = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] c_out;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         z_flag, n_flag, v_flag, v_sticky;
    logic         clr_v = 1'b0;

    alu_stage #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ain       (ain),
        .sout      (sout),
        .alu_op    (alu_op),
        .load_s    (load_s),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .c_out     (c_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z_flag    (z_flag),
        .n_flag    (n_flag),
        .v_flag    (v_flag),
        .v_sticky  (v_sticky),
        .clr_v     (clr_v)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] c;
        logic         z;
        logic         n;
        logic         v;
        logic         st;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [W-1:0] m_c = '0;
    logic         m_valid = 1'b0;
    logic         m_z = 1'b1, m_n = 1'b0, m_v = 1'b0, m_st = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".c_out"},     32'(c_out),     32'(m_c));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".z"},         32'(z_flag),    32'(m_z));
        check({tag, ".n"},         32'(n_flag),    32'(m_n));
        check({tag, ".v"},         32'(v_flag),    32'(m_v));
        check({tag, ".sticky"},    32'(v_sticky),  32'(m_st));
    endtask

    function automatic void model_op(input logic [1:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, output logic [W-1:0] r,
                                     output logic ov);
        ov = 1'b0;
        case (op)
            2'b00: begin
                r  = a + b;
                ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            2'b01: begin
                r  = a - b;
                ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            2'b10: r = a & b;
            default: r = ~b;
        endcase
    endfunction

    // One clock of stimulus, entered and left at posedge+1.
    task automatic step(input string tag, input logic vld, input logic [1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic ls,
                        input logic ordy, input logic clr);
        logic         exp_rdy, acc, ov;
        logic [W-1:0] r;
        exp_t         e, got;
        in_valid  = vld;
        alu_op    = op;
        ain       = a;
        sout      = b;
        load_s    = ls;
        out_ready = ordy;
        clr_v     = clr;
        #1;
        exp_rdy = !m_valid || ordy;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
        acc = vld && exp_rdy;
        model_op(op, a, b, r, ov);
        if (clr) m_st = 1'b0;
        if (acc) begin
            m_c     = r;
            m_valid = 1'b1;
            if (ls) begin
                m_z = (r == '0);
                m_n = r[W-1];
                m_v = ov;
                if (ov) m_st = 1'b1;
            end
            e = '{c: m_c, z: m_z, n: m_n, v: m_v, st: m_st};
            sb.push_back(e);
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        if (acc) begin
            got = '{c: c_out, z: z_flag, n: n_flag, v: v_flag, st: v_sticky};
            e = sb.pop_front();
            check({tag, ".sb"}, 32'(got), 32'(e));
        end
        check_all(tag);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check_all("reset");
        check("reset.in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        step("add_3_5",    1, 2'b00, 16'h0003, 16'h0005, 1, 1, 0);
        check("add_3_5.val", 32'(c_out), 32'h0008);
        step("sub_eq",     1, 2'b01, 16'h0004, 16'h0004, 1, 1, 0);
        check("sub_eq.z", 32'(z_flag), 32'd1);
        step("add_ovf",    1, 2'b00, 16'h7FFF, 16'h0001, 1, 1, 0);
        check("add_ovf.val", 32'(c_out), 32'h8000);
        step("and",        1, 2'b10, 16'hF0F0, 16'h3C3C, 1, 1, 0);
        check("and.val", 32'(c_out), 32'h3030);
        step("not",        1, 2'b11, 16'h1234, 16'h8000, 1, 1, 0);
        check("not.val", 32'(c_out), 32'h7FFF);
        step("idle_hold",  0, 2'b00, 16'h0000, 16'h0000, 1, 1, 0);
        step("clr_v",      0, 2'b00, 16'h0000, 16'h0000, 0, 1, 1);
        check("clr_v.sticky", 32'(v_sticky), 32'd0);

        // Back-pressure: result held, later operand changes ignored, then no-bubble accept.
        step("pre_stall",  1, 2'b00, 16'h0001, 16'h0001, 1, 0, 0);
        step("stall1",     1, 2'b00, 16'h0010, 16'h0020, 1, 0, 0);
        step("stall2",     1, 2'b01, 16'h5555, 16'h1111, 1, 0, 0);
        step("stall3",     1, 2'b00, 16'h0010, 16'h0020, 1, 0, 0);
        check("stall.hold", 32'(c_out), 32'h0002);
        step("release",    1, 2'b00, 16'h0010, 16'h0020, 1, 1, 0);
        check("release.val", 32'(c_out), 32'h0030);

        step("no_loads",   1, 2'b01, 16'h0001, 16'h0002, 0, 1, 0);
        check("no_loads.val", 32'(c_out), 32'hFFFF);
        step("clr_and_set", 1, 2'b00, 16'h8000, 16'h8000, 1, 1, 1);
        check("clr_and_set.sticky", 32'(v_sticky), 32'd1);
        step("sub_ovf_neg", 1, 2'b01, 16'h8000, 16'h0001, 1, 1, 0);
        step("sub_ovf_pos", 1, 2'b01, 16'h7FFF, 16'hFFFF, 1, 1, 0);
        step("sub_noovf",   1, 2'b01, 16'h0002, 16'h0005, 1, 1, 0);
        for (int i = 0; i < 6; i++) begin
            step("rand", 1, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a stall discards the pending result immediately.
        step("pre_rst",    1, 2'b00, 16'h0005, 16'h0006, 1, 0, 0);
        step("pre_rst2",   1, 2'b00, 16'h0005, 16'h0006, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        m_c = '0; m_valid = 1'b0; m_z = 1'b1; m_n = 1'b0; m_v = 1'b0; m_st = 1'b0;
        sb.delete();
        check_all("mid_rst");
        check("mid_rst.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("post_rst",   1, 2'b00, 16'h0003, 16'h0005, 1, 1, 0);
        check("post_rst.val", 32'(c_out), 32'h0008);
        step("drain",      0, 2'b00, 16'h0000, 16'h0000, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_stage.md
# alu_stage

Registered ALU stage sitting directly downstream of the shifter in the datapath. It consumes the A operand and the shifter output `sout`, computes one of four ALU operations, and holds the result in an output register (C) with a valid/ready handshake toward writeback. It also maintains the status register (Z, N, V) used by conditional branches, including a sticky overflow bit.

## Interface
- `WIDTH`, 16: datapath width; all operands and results.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ain`  in  WIDTH  A operand from the A register.
- `sout`  in  WIDTH  B operand, taken directly from the shifter output.
- `alu_op`  in  2  00 ADD, 01 SUB (ain − sout), 10 AND, 11 NOT (~sout; ain ignored).
- `load_s`  in  1  when the transfer is accepted, the result updates Z/N/V.
- `in_valid`  in  1  operands and op are valid this cycle.
- `in_ready`  out  1  stage can accept this cycle.
- `c_out`  out  WIDTH  registered result (C register).
- `out_valid`  out  1  `c_out` holds an unconsumed result.
- `out_ready`  in  1  downstream consumes `c_out` this cycle.
- `z_flag`, `n_flag`, `v_flag`  out  1 each  status register.
- `v_sticky`  out  1  set by any overflowing ADD/SUB accepted with `load_s`; cleared only by `clr_v` or reset.
- `clr_v`  in  1  synchronous clear of `v_sticky`.

## Operation
- Accept: `in_valid && in_ready`. `in_ready = !out_valid || out_ready`, combinational, so throughput is one operation per cycle.
- On accept: `c_out` ← result and `out_valid` ← 1. If `out_valid && out_ready` and there is no accept, then `out_valid` ← 0 and `c_out` holds its value.
- Arithmetic is modulo 2^WIDTH with no carry out. V applies to ADD/SUB only: ADD sets V when the operands have the same sign and the result sign differs. SUB sets V when the operand signs differ and the result sign differs from `ain`. AND and NOT force V = 0.
- Z = (result == 0). N = result[WIDTH−1].
- Status update happens only on accept with `load_s` = 1. Otherwise Z/N/V hold.
- `v_sticky` ← `v_sticky` | V on any status update. If `clr_v` and a setting update occur in the same cycle, the set wins and `v_sticky` = 1.
- Result depends only on the operands presented in the accept cycle. Later changes to `ain`/`sout` have no effect.

## Timing
- Reset (asynchronous assert, synchronous deassert externally): `c_out` = 0, `out_valid` = 0, `z_flag` = 1, `n_flag` = 0, `v_flag` = 0, `v_sticky` = 0. `in_ready` is therefore 1 during and after reset.
- Latency: 1 cycle from accept edge to `c_out`/`out_valid` and flags.
- Stall: while `out_valid` = 1 and `out_ready` = 0, `in_ready` = 0. `c_out`, `out_valid` and flags hold stable, and inputs are ignored.
- Simultaneous consume and accept: the new result replaces the old in the same edge and `out_valid` stays 1. No bubble.
- Reset mid-stall: the pending result is discarded. After `rst_n` rises, the first accepted op completes normally.

## Structure
- Shared package `datapath_pkg`:
  - `alu_op_t` enum (ALU_ADD, ALU_SUB, ALU_AND, ALU_NOT).
  - The shifter's `shift_t` codes (00 pass, 01 left, 10 logical right, 11 arithmetic right), so both stages share one definition.
  - `WIDTH` default.
- One combinational sub-module, `alu_core`: `ain`, `sout`, `alu_op` → result, V. `alu_stage` wraps it with the C register, handshake and status/sticky registers.

## Test plan
- After reset, ADD 0x0003 + 0x0005 with `load_s` = 1 → next cycle `c_out` = 0x0008, `out_valid` = 1, Z = 0, N = 0, V = 0.
- SUB 0x0004 − 0x0004 → `c_out` = 0x0000, Z = 1. Then ADD 0x7FFF + 0x0001 → `c_out` = 0x8000, N = 1, V = 1, `v_sticky` = 1.
- AND 0xF0F0 & 0x3C3C → 0x3030. NOT with `sout` = 0x8000 → 0x7FFF. V = 0 on both. `v_sticky` stays 1 until `clr_v` is pulsed, then reads 0.
- Hold `out_ready` = 0 for 3 cycles with `in_valid` = 1 → `in_ready` = 0 and `c_out` is unchanged. Then assert `out_ready` → the new result lands on the same edge, with no bubble and no lost op.
- `load_s` = 0 on SUB 0x0001 − 0x0002 → `c_out` = 0xFFFF while flags keep their prior values. Same cycle `clr_v` + overflowing ADD with `load_s` = 1 → `v_sticky` = 1.
- Assert `rst_n` = 0 mid-stall → all outputs take their reset values immediately (asynchronous reset), and `in_ready` = 1.
